// File: rtl/jtbubl_pkg.sv
// Shared definitions for the Bubble Bobble scan-line buffer.
// Pixel width, erase value and transparency test.
package jtbubl_pkg;

  localparam int PW = 11;
  localparam logic [PW-1:0] EMPTY_COL = 11'h00F;

  typedef enum logic {
    ST_CLR,
    ST_RUN
  } state_t;

  function automatic logic transp(input logic [PW-1:0] d);
    return d[3:0] == 4'hF;
  endfunction

endpackage

// File: rtl/jtbubl_linebuf_bank.sv
// One line-buffer bank: clear/renderer writes on port 0,
// readout and erase-behind on port 1.
import jtbubl_pkg::*;

module jtbubl_linebuf_bank #(
  parameter int AW = 8,
  parameter logic [PW-1:0] EMPTY = EMPTY_COL
) (
  input  logic          clk,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_data,
  input  logic          er_en,
  input  logic [AW-1:0] er_addr,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_data
);

  logic          we0;
  logic [AW-1:0] addr0;
  logic [PW-1:0] data0;
  logic [AW-1:0] addr1;

  always_comb begin
    we0   = 1'b0;
    addr0 = wr_addr;
    data0 = wr_data;
    unique case (1'b1)
      clr_en: begin
        we0   = 1'b1;
        addr0 = clr_addr;
        data0 = EMPTY;
      end
      wr_en: we0 = 1'b1;
      default: ;
    endcase
  end

  assign addr1 = er_en ? er_addr : rd_addr;

  jtframe_dual_ram #(
    .DW(PW),
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .data0(data0),
    .addr0(addr0),
    .we0  (we0),
    .data1(EMPTY),
    .addr1(addr1),
    .we1  (er_en),
    .q1   (rd_data)
  );

endmodule

// File: rtl/jtframe_dual_ram.sv
// Single-clock dual-port RAM: port 0 write-only,
// port 1 read/write with registered read data.
module jtframe_dual_ram #(
  parameter int DW = 11,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  input  logic [DW-1:0] data1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem [2**AW];

  // Port 0 is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (we1) mem[addr1] <= data1;
    if (we0) mem[addr0] <= data0;
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtbubl_linebuf.sv
// Double-buffered scan-line buffer feeding the colour mixer.
// Renderer fills one bank while the other is streamed and erased.
import jtbubl_pkg::*;

module jtbubl_linebuf #(
  parameter logic [PW-1:0] EMPTY = EMPTY_COL,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [AW-1:0] hdump,
  input  logic [PW-1:0] bg_col,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_data,
  output logic [PW-1:0] col_addr,
  output logic          bank,
  output logic          ready
);

  state_t        st_q;
  logic [AW+1:0] cnt_q;
  logic          bank_q;
  logic          ready_q;
  logic          lhbl_q;
  logic          rd_vld_q;
  logic          rd_bank_q;
  logic [AW-1:0] rd_addr_q;
  logic [PW-1:0] col_q;

  logic          run;
  logic          fall;
  logic          rd_issue;
  logic [PW-1:0] q [2];
  logic [PW-1:0] rd_data;

  assign run      = st_q == ST_RUN;
  assign fall     = run & lhbl_q & ~LHBL;
  assign rd_issue = run & pxl_cen & LHBL;
  assign rd_data  = rd_bank_q ? q[1] : q[0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    jtbubl_linebuf_bank #(
      .AW   (AW),
      .EMPTY(EMPTY)
    ) u_bank (
      .clk     (clk),
      .clr_en  (~run & ~cnt_q[AW+1] & (cnt_q[AW] == 1'(b))),
      .clr_addr(cnt_q[AW-1:0]),
      .wr_en   (run & wr_en & ~transp(wr_data) & (bank_q == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .er_en   (rd_vld_q & (rd_bank_q == 1'(b))),
      .er_addr (rd_addr_q),
      .rd_addr (hdump),
      .rd_data (q[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_CLR;
      cnt_q     <= '0;
      bank_q    <= 1'b0;
      ready_q   <= 1'b0;
      lhbl_q    <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      col_q     <= '0;
    end else begin
      lhbl_q   <= LHBL;
      rd_vld_q <= rd_issue;
      // Latch the bank at issue so a swap mid-read keeps the old bank
      if (rd_issue) begin
        rd_addr_q <= hdump;
        rd_bank_q <= ~bank_q;
      end
      unique case (st_q)
        ST_CLR: begin
          col_q  <= '0;
          bank_q <= 1'b0;
          if (cnt_q[AW+1]) begin
            st_q    <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + (AW+2)'(1);
          end
        end
        ST_RUN: begin
          if (fall) bank_q <= ~bank_q;
          if (rd_vld_q)
            col_q <= transp(rd_data) ? bg_col : rd_data;
          else if (pxl_cen & ~LHBL)
            col_q <= '0;
        end
      endcase
    end
  end

  assign col_addr = col_q;
  assign bank     = bank_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_jtbubl_linebuf.sv
// Self-checking bench for jtbubl_linebuf against a
// line-level model of both banks.
module tb_jtbubl_linebuf;

  localparam int AW = 8;
  localparam logic [10:0] EMP = 11'h00F;

  logic          clk = 1'b0;
  logic          rst;
  logic          pxl_cen;
  logic          LHBL;
  logic [AW-1:0] hdump;
  logic [10:0]   bg_col;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [10:0]   wr_data;
  logic [10:0]   col_addr;
  logic          bank;
  logic          ready;

  int checks = 0;
  int fails  = 0;

  logic [10:0] mem [2][256];
  int          mbank;

  jtbubl_linebuf #(.EMPTY(EMP), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .LHBL    (LHBL),
    .hdump   (hdump),
    .bg_col  (bg_col),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .col_addr(col_addr),
    .bank    (bank),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++)
        mem[b][a] = EMP;
    mbank = 0;
  endtask

  task automatic wr(input int a, input logic [10:0] d);
    wr_addr = AW'(a);
    wr_data = d;
    wr_en   = 1'b1;
    tick;
    wr_en = 1'b0;
    if (d[3:0] != 4'hF) mem[mbank][a] = d;
  endtask

  task automatic pix(input int a);
    int          rb;
    logic [10:0] v;
    logic [10:0] exp;
    rb  = 1 - mbank;
    v   = mem[rb][a];
    exp = (v[3:0] == 4'hF) ? bg_col : v;
    mem[rb][a] = EMP;
    hdump   = AW'(a);
    pxl_cen = 1'b1;
    tick;
    pxl_cen = 1'b0;
    tick;
    check("pixel", col_addr, exp);
    tick;
  endtask

  task automatic line_end(input bit swr, input int a, input logic [10:0] d);
    LHBL = 1'b0;
    if (swr) begin
      wr_addr = AW'(a);
      wr_data = d;
      wr_en   = 1'b1;
      if (d[3:0] != 4'hF) mem[mbank][a] = d;
    end
    tick;
    wr_en = 1'b0;
    mbank = 1 - mbank;
    check("swap", bank, mbank);
    pxl_cen = 1'b1;
    tick;
    pxl_cen = 1'b0;
    tick;
    check("blank", col_addr, 0);
    tick;
    LHBL = 1'b1;
    tick;
    tick;
    check("swap_once", bank, mbank);
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (!ready && n < 600) begin
      tick;
      n++;
    end
    check("ready_lat", n, 513);
  endtask

  initial begin
    rst     = 1'b1;
    pxl_cen = 1'b0;
    LHBL    = 1'b1;
    hdump   = '0;
    bg_col  = 11'h5A0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    model_clear();

    tick;
    tick;
    check("rst_col", col_addr, 0);
    check("rst_bank", bank, 0);
    check("rst_ready", ready, 0);
    rst = 1'b0;
    wait_ready();

    // Both banks must read back as cleared
    for (int a = 0; a < 256; a++) pix(a);
    bg_col = 11'h0C3;
    line_end(1'b0, 0, '0);
    for (int a = 0; a < 256; a++) pix(a);

    // Directed: write, transparency, overwrite, swap-clock write
    wr(10, 11'h123);
    wr(5, 11'h12F);
    wr(5, 11'h340);
    wr(7, 11'h34F);
    line_end(1'b0, 0, '0);
    pix(10);
    pix(5);
    pix(7);
    pix(11);
    line_end(1'b1, 20, 11'h2A1);
    pix(20);
    pix(10);
    line_end(1'b0, 0, '0);
    pix(10);
    pix(5);

    // Randomized lines over a narrow column range for frequent hits
    for (int l = 0; l < 6; l++) begin
      bg_col = 11'($urandom_range(0, 2047)) & 11'h7F0;
      for (int i = 0; i < 30; i++) begin
        logic [10:0] d;
        d = 11'($urandom);
        if ($urandom_range(0, 9) < 3) d[3:0] = 4'hF;
        if ($urandom_range(0, 1) == 0) wr($urandom_range(0, 15), d);
        else pix($urandom_range(0, 15));
      end
      line_end($urandom_range(0, 1) == 1, $urandom_range(0, 15),
               11'($urandom) | 11'h001);
    end

    // Mid-line reset with pending data in both banks
    wr(3, 11'h456);
    wr(100, 11'h789);
    line_end(1'b0, 0, '0);
    wr(100, 11'h111);
    pix(98);
    hdump   = AW'(100);
    pxl_cen = 1'b1;
    rst     = 1'b1;
    tick;
    rst     = 1'b0;
    pxl_cen = 1'b0;
    check("mid_rst_col", col_addr, 0);
    check("mid_rst_bank", bank, 0);
    check("mid_rst_ready", ready, 0);
    model_clear();
    wr_addr = AW'(3);
    wr_data = 11'h456;
    wr_en   = 1'b1;
    wait_ready();
    wr_en = 1'b0;
    bg_col = 11'h2B0;
    for (int a = 0; a < 8; a++) pix(a);
    pix(100);
    line_end(1'b0, 0, '0);
    for (int a = 0; a < 8; a++) pix(a);
    pix(100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
